// File: rtl/mips_16_core_top_pkg.sv
// Shared widths, opcode encodings and ALU command codes for the 16-bit single-cycle core.
package mips_16_core_top_pkg;

  localparam int WIDTH   = 16;
  localparam int IADDR_W = 8;
  localparam int DADDR_W = 8;

  localparam logic [3:0] OP_NOP  = 4'b0000;
  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_SUB  = 4'b0010;
  localparam logic [3:0] OP_AND  = 4'b0011;
  localparam logic [3:0] OP_OR   = 4'b0100;
  localparam logic [3:0] OP_XOR  = 4'b0101;
  localparam logic [3:0] OP_SL   = 4'b0110;
  localparam logic [3:0] OP_SR   = 4'b0111;
  localparam logic [3:0] OP_SRU  = 4'b1000;
  localparam logic [3:0] OP_ADDI = 4'b1001;
  localparam logic [3:0] OP_LD   = 4'b1010;
  localparam logic [3:0] OP_ST   = 4'b1011;
  localparam logic [3:0] OP_BZ   = 4'b1100;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_XOR = 3'b100,
    ALU_SL  = 3'b101,
    ALU_SR  = 3'b110,
    ALU_SRU = 3'b111
  } alu_cmd_e;

  // Shift amounts use only the low four bits of the second operand.
  function automatic logic [WIDTH-1:0] alu_eval(input alu_cmd_e cmd,
                                                input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] y;
    y = '0;
    case (cmd)
      ALU_ADD: y = a + b;
      ALU_SUB: y = a - b;
      ALU_AND: y = a & b;
      ALU_OR:  y = a | b;
      ALU_XOR: y = a ^ b;
      ALU_SL:  y = a << b[3:0];
      ALU_SR:  y = $signed(a) >>> b[3:0];
      ALU_SRU: y = a >> b[3:0];
      default: y = '0;
    endcase
    return y;
  endfunction

endpackage

// File: rtl/mips_16_core_top_mem.sv
// Instruction and data memories plus the thin fetch/memory stage wrappers around them.
module mips_16_imem
  import mips_16_core_top_pkg::*;
(
  input  logic [IADDR_W-1:0] addr,
  output logic [WIDTH-1:0]   data
);
  // Loaded and patched from outside; the core only reads it.
  logic [WIDTH-1:0] rom [0:(1<<IADDR_W)-1];
  assign data = rom[addr];
endmodule

module mips_16_dmem
  import mips_16_core_top_pkg::*;
(
  input  logic               clk,
  input  logic               we,
  input  logic [DADDR_W-1:0] addr,
  input  logic [WIDTH-1:0]   wdata,
  output logic [WIDTH-1:0]   rdata
);
  logic [WIDTH-1:0] ram [0:(1<<DADDR_W)-1];

  always_ff @(posedge clk) begin
    if (we) ram[addr] <= wdata;
  end

  assign rdata = ram[addr];
endmodule

module mips_16_if_stage
  import mips_16_core_top_pkg::*;
(
  input  logic [IADDR_W-1:0] pc,
  output logic [WIDTH-1:0]   instr
);
  mips_16_imem imem (.addr(pc), .data(instr));
endmodule

module mips_16_mem_stage
  import mips_16_core_top_pkg::*;
(
  input  logic               clk,
  input  logic               we,
  input  logic [DADDR_W-1:0] addr,
  input  logic [WIDTH-1:0]   wdata,
  output logic [WIDTH-1:0]   rdata
);
  mips_16_dmem dmem (.clk(clk), .we(we), .addr(addr), .wdata(wdata), .rdata(rdata));
endmodule

// File: rtl/mips_16_regfile.sv
// Eight-entry register file: three combinational read ports, one synchronous write port.
module mips_16_regfile
  import mips_16_core_top_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       ra1,
  input  logic [2:0]       ra2,
  input  logic [2:0]       ra3,
  output logic [WIDTH-1:0] rd1,
  output logic [WIDTH-1:0] rd2,
  output logic [WIDTH-1:0] rd3,
  input  logic             we,
  input  logic [2:0]       wa,
  input  logic [WIDTH-1:0] wd
);

  logic [WIDTH-1:0] re_array [0:7];

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 8; i++) re_array[i] <= '0;
    end else if (we && (wa != 3'd0)) begin
      re_array[wa] <= wd;
    end
  end

  // r0 is forced to zero on read so it never depends on reset having happened.
  assign rd1 = (ra1 == 3'd0) ? '0 : re_array[ra1];
  assign rd2 = (ra2 == 3'd0) ? '0 : re_array[ra2];
  assign rd3 = (ra3 == 3'd0) ? '0 : re_array[ra3];

endmodule

// File: rtl/mips_16_core_top.sv
// Single-cycle 16-bit core: fetch, decode, execute, memory and writeback within one clock.
module mips_16_core_top
  import mips_16_core_top_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  output logic [IADDR_W-1:0] pc
);

  logic [WIDTH-1:0]   instr;
  logic [3:0]         op;
  logic [2:0]         rd_idx, rs_idx, rt_idx;
  logic [WIDTH-1:0]   imm16;
  logic [WIDTH-1:0]   rs_val, rt_val, rd_val;
  logic [WIDTH-1:0]   alu_b, alu_y, mem_rdata, wb_data;
  alu_cmd_e           alu_cmd;
  logic               reg_we, ram_we, wb_mem, br_taken;
  logic [IADDR_W-1:0] pc_next;

  mips_16_if_stage IF_stage_inst (.pc(pc), .instr(instr));

  assign op     = instr[15:12];
  assign rd_idx = instr[11:9];
  assign rs_idx = instr[8:6];
  assign rt_idx = instr[5:3];
  assign imm16  = {{(WIDTH-6){instr[5]}}, instr[5:0]};

  mips_16_regfile check_inst (
    .clk (clk),
    .rst (rst),
    .ra1 (rs_idx),
    .ra2 (rt_idx),
    .ra3 (rd_idx),
    .rd1 (rs_val),
    .rd2 (rt_val),
    .rd3 (rd_val),
    .we  (reg_we && rst),
    .wa  (rd_idx),
    .wd  (wb_data)
  );

  always_comb begin
    alu_cmd  = ALU_ADD;
    alu_b    = rt_val;
    reg_we   = 1'b0;
    ram_we   = 1'b0;
    wb_mem   = 1'b0;
    br_taken = 1'b0;
    case (op)
      OP_ADD:  begin alu_cmd = ALU_ADD; reg_we = 1'b1; end
      OP_SUB:  begin alu_cmd = ALU_SUB; reg_we = 1'b1; end
      OP_AND:  begin alu_cmd = ALU_AND; reg_we = 1'b1; end
      OP_OR:   begin alu_cmd = ALU_OR;  reg_we = 1'b1; end
      OP_XOR:  begin alu_cmd = ALU_XOR; reg_we = 1'b1; end
      OP_SL:   begin alu_cmd = ALU_SL;  reg_we = 1'b1; end
      OP_SR:   begin alu_cmd = ALU_SR;  reg_we = 1'b1; end
      OP_SRU:  begin alu_cmd = ALU_SRU; reg_we = 1'b1; end
      OP_ADDI: begin alu_b = imm16; reg_we = 1'b1; end
      OP_LD:   begin alu_b = imm16; reg_we = 1'b1; wb_mem = 1'b1; end
      OP_ST:   begin alu_b = imm16; ram_we = 1'b1; end
      OP_BZ:   br_taken = (rs_val == '0);
      default: ; // NOP and the unassigned opcodes
    endcase
  end

  assign alu_y   = alu_eval(alu_cmd, rs_val, alu_b);
  assign wb_data = wb_mem ? mem_rdata : alu_y;

  // A store issued while reset is held must not reach memory.
  mips_16_mem_stage MEM_stage_inst (
    .clk   (clk),
    .we    (ram_we && rst),
    .addr  (alu_y[DADDR_W-1:0]),
    .wdata (rd_val),
    .rdata (mem_rdata)
  );

  assign pc_next = br_taken ? (pc + 8'd1 + imm16[7:0]) : (pc + 8'd1);

  always_ff @(posedge clk) begin
    if (!rst) pc <= '0;
    else      pc <= pc_next;
  end

endmodule

// File: tb/tb_mips_16_core_top.sv
// Bench for mips_16_core_top: directed programs plus random programs against an ISA-level model.
module tb_mips_16_core_top;

  logic       clk;
  logic       rst;
  logic [7:0] pc;

  int n_checks = 0;
  int n_errors = 0;

  logic [15:0] m_rom [256];
  logic [15:0] m_ram [256];
  logic [15:0] m_reg [8];
  logic [7:0]  m_pc;

  mips_16_core_top dut (.clk(clk), .rst(rst), .pc(pc));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic poke_rom(input int a, input logic [15:0] v);
    dut.IF_stage_inst.imem.rom[a] = v;
    m_rom[a] = v;
  endtask

  task automatic poke_ram(input int a, input logic [15:0] v);
    dut.MEM_stage_inst.dmem.ram[a] = v;
    m_ram[a] = v;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) begin
      poke_rom(i, 16'h0000);
      poke_ram(i, 16'h0000);
    end
  endtask

  task automatic model_reset();
    m_pc = 8'd0;
    for (int i = 0; i < 8; i++) m_reg[i] = 16'h0000;
  endtask

  // Executes one instruction of the ISA directly from the model state.
  task automatic model_step();
    logic [15:0] ins, a, b, imm, res;
    logic [3:0]  op;
    int          rd, rs, rt, sh;
    bit          wr;
    ins = m_rom[m_pc];
    op  = ins[15:12];
    rd  = int'(ins[11:9]);
    rs  = int'(ins[8:6]);
    rt  = int'(ins[5:3]);
    imm = {{10{ins[5]}}, ins[5:0]};
    a   = m_reg[rs];
    b   = m_reg[rt];
    sh  = int'(b[3:0]);
    res = 16'h0000;
    wr  = 1'b1;
    case (op)
      4'd1:  res = a + b;
      4'd2:  res = a - b;
      4'd3:  res = a & b;
      4'd4:  res = a | b;
      4'd5:  res = a ^ b;
      4'd6:  res = a << sh;
      4'd7:  begin
        res = a >> sh;
        if (a[15]) res = res | ~(16'hFFFF >> sh);
      end
      4'd8:  res = a >> sh;
      4'd9:  res = a + imm;
      4'd10: begin
        b   = a + imm;
        res = m_ram[b[7:0]];
      end
      4'd11: begin
        b = a + imm;
        m_ram[b[7:0]] = m_reg[rd];
        wr = 1'b0;
      end
      default: wr = 1'b0;
    endcase
    if (wr && rd != 0) m_reg[rd] = res;
    if (op == 4'd12 && a == 16'h0000) m_pc = m_pc + 8'd1 + imm[7:0];
    else                              m_pc = m_pc + 8'd1;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic test_reset();
    clear_mem();
    rst = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    n_checks++;
    if (pc !== 8'd0) begin
      n_errors++;
      $display("FAIL reset_pc: got %0d expected 0", pc);
    end
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if (dut.check_inst.re_array[i] !== 16'h0000) begin
        n_errors++;
        $display("FAIL reset_reg%0d: got %h expected 0000", i, dut.check_inst.re_array[i]);
      end
    end
    rst = 1'b1;
    tick();
    n_checks++;
    if (pc !== 8'd1) begin
      n_errors++;
      $display("FAIL reset_first_edge_pc: got %0d expected 1", pc);
    end
  endtask

  task automatic test_addi_chain();
    clear_mem();
    poke_rom(0, 16'h9208);
    poke_rom(1, 16'h9448);
    do_reset();
    tick();
    tick();
    n_checks++;
    if (dut.check_inst.re_array[1] !== 16'd8) begin
      n_errors++;
      $display("FAIL addi_r1: got %h expected 0008", dut.check_inst.re_array[1]);
    end
    n_checks++;
    if (dut.check_inst.re_array[2] !== 16'd16) begin
      n_errors++;
      $display("FAIL addi_r2: got %h expected 0010", dut.check_inst.re_array[2]);
    end
  endtask

  task automatic test_store_load();
    clear_mem();
    poke_ram(10, 16'h1234);
    poke_rom(0, 16'h9208);
    poke_rom(1, 16'h9448);
    poke_rom(2, 16'h9605);
    poke_rom(3, 16'hB642);
    poke_rom(4, 16'hAA42);
    do_reset();
    for (int i = 0; i < 5; i++) tick();
    n_checks++;
    if (dut.MEM_stage_inst.dmem.ram[10] !== 16'd5) begin
      n_errors++;
      $display("FAIL st_ram10: got %h expected 0005", dut.MEM_stage_inst.dmem.ram[10]);
    end
    n_checks++;
    if (dut.check_inst.re_array[5] !== 16'd5) begin
      n_errors++;
      $display("FAIL ld_r5: got %h expected 0005", dut.check_inst.re_array[5]);
    end
  endtask

  task automatic test_branch();
    clear_mem();
    poke_rom(7, 16'hC1B8);
    do_reset();
    for (int i = 0; i < 7; i++) tick();
    n_checks++;
    if (pc !== 8'd7) begin
      n_errors++;
      $display("FAIL bz_reach7: got %0d expected 7", pc);
    end
    tick();
    n_checks++;
    if (pc !== 8'd0) begin
      n_errors++;
      $display("FAIL bz_taken: got %0d expected 0", pc);
    end
    poke_rom(0, 16'h9C01);
    do_reset();
    for (int i = 0; i < 8; i++) tick();
    n_checks++;
    if (pc !== 8'd8) begin
      n_errors++;
      $display("FAIL bz_not_taken: got %0d expected 8", pc);
    end
  endtask

  task automatic test_alu_corners();
    logic [15:0] prog [10];
    prog[0] = 16'h9201; prog[1] = 16'h2408; prog[2] = 16'h9601; prog[3] = 16'h980F;
    prog[4] = 16'h66E0; prog[5] = 16'h7AE0; prog[6] = 16'h8CE0; prog[7] = 16'h9045;
    prog[8] = 16'hF3FF; prog[9] = 16'hD249;
    clear_mem();
    for (int i = 0; i < 10; i++) poke_rom(i, prog[i]);
    do_reset();
    for (int i = 0; i < 10; i++) tick();
    n_checks++;
    if (dut.check_inst.re_array[2] !== 16'hFFFF) begin
      n_errors++;
      $display("FAIL sub_0_minus_1: got %h expected ffff", dut.check_inst.re_array[2]);
    end
    n_checks++;
    if (dut.check_inst.re_array[3] !== 16'h8000) begin
      n_errors++;
      $display("FAIL sl_1_by_15: got %h expected 8000", dut.check_inst.re_array[3]);
    end
    n_checks++;
    if (dut.check_inst.re_array[5] !== 16'hFFFF) begin
      n_errors++;
      $display("FAIL sr_8000_by_15: got %h expected ffff", dut.check_inst.re_array[5]);
    end
    n_checks++;
    if (dut.check_inst.re_array[6] !== 16'h0001) begin
      n_errors++;
      $display("FAIL sru_8000_by_15: got %h expected 0001", dut.check_inst.re_array[6]);
    end
    n_checks++;
    if (dut.check_inst.re_array[0] !== 16'h0000) begin
      n_errors++;
      $display("FAIL r0_write: got %h expected 0000", dut.check_inst.re_array[0]);
    end
    n_checks++;
    if (dut.check_inst.re_array[1] !== 16'h0001) begin
      n_errors++;
      $display("FAIL unused_op_nop: got %h expected 0001", dut.check_inst.re_array[1]);
    end
    n_checks++;
    if (pc !== 8'd10) begin
      n_errors++;
      $display("FAIL alu_pc: got %0d expected 10", pc);
    end
  endtask

  task automatic test_wrap();
    clear_mem();
    do_reset();
    for (int i = 0; i < 255; i++) tick();
    n_checks++;
    if (pc !== 8'd255) begin
      n_errors++;
      $display("FAIL wrap_reach255: got %0d expected 255", pc);
    end
    tick();
    n_checks++;
    if (pc !== 8'd0) begin
      n_errors++;
      $display("FAIL wrap_to0: got %0d expected 0", pc);
    end
  endtask

  task automatic test_reset_mid();
    clear_mem();
    poke_ram(20, 16'hAAAA);
    poke_rom(0, 16'h9207);
    poke_rom(1, 16'hB214);
    do_reset();
    tick();
    rst = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    n_checks++;
    if (pc !== 8'd0 || dut.check_inst.re_array[1] !== 16'h0000) begin
      n_errors++;
      $display("FAIL mid_reset_state: got pc=%0d r1=%h expected pc=0 r1=0000", pc, dut.check_inst.re_array[1]);
    end
    n_checks++;
    if (dut.MEM_stage_inst.dmem.ram[20] !== 16'hAAAA) begin
      n_errors++;
      $display("FAIL mid_reset_no_store: got %h expected aaaa", dut.MEM_stage_inst.dmem.ram[20]);
    end
    rst = 1'b1;
    tick();
    tick();
    n_checks++;
    if (pc !== 8'd2 || dut.MEM_stage_inst.dmem.ram[20] !== 16'h0007) begin
      n_errors++;
      $display("FAIL mid_reset_restart: got pc=%0d ram20=%h expected pc=2 ram20=0007", pc, dut.MEM_stage_inst.dmem.ram[20]);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 256; i++) begin
      poke_rom(i, {4'($urandom_range(0, 15)), 12'($urandom)});
      poke_ram(i, 16'($urandom));
    end
    do_reset();
    for (int c = 0; c < 400; c++) begin
      if (c % 50 == 25) poke_rom($urandom_range(0, 255), {4'($urandom_range(0, 15)), 12'($urandom)});
      tick();
      n_checks++;
      if (pc !== m_pc) begin
        n_errors++;
        $display("FAIL rand_pc cycle %0d: got %0d expected %0d", c, pc, m_pc);
      end
      for (int r = 0; r < 8; r++) begin
        n_checks++;
        if (dut.check_inst.re_array[r] !== m_reg[r]) begin
          n_errors++;
          $display("FAIL rand_reg%0d cycle %0d: got %h expected %h", r, c, dut.check_inst.re_array[r], m_reg[r]);
        end
      end
    end
    for (int i = 0; i < 256; i++) begin
      n_checks++;
      if (dut.MEM_stage_inst.dmem.ram[i] !== m_ram[i]) begin
        n_errors++;
        $display("FAIL rand_ram%0d: got %h expected %h", i, dut.MEM_stage_inst.dmem.ram[i], m_ram[i]);
      end
    end
  endtask

  initial begin
    rst = 1'b0;
    test_reset();
    test_addi_chain();
    test_store_load();
    test_branch();
    test_alu_corners();
    test_wrap();
    test_reset_mid();
    for (int k = 0; k < 3; k++) test_random();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
